// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation encodings and packed flag-bus layout
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_LTS = 4;
    localparam int FLAG_LTU = 5;
    localparam int NFLAGS   = 6;

endpackage

// File: rtl/restador_etapa.sv
// restador_etapa: one carry-chain chunk of the pipelined adder plus its pipeline registers
module restador_etapa
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 16,
    parameter int K     = 0,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] part,
    input  logic             carry,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             valid_d,
    output logic [WIDTH-1:0] a_d,
    output logic [WIDTH-1:0] b_d,
    output logic [WIDTH-1:0] part_d,
    output logic             carry_d,
    output logic             sub_d,
    output logic [TAG_W-1:0] tag_d
);

    logic [CW-1:0]    sum;
    logic             carry_nx;
    logic [WIDTH-1:0] part_nx;

    assign {carry_nx, sum} = {1'b0, a[K*CW +: CW]} + {1'b0, b[K*CW +: CW]} + {{CW{1'b0}}, carry};

    // Splice this stage's chunk into the partial result carried down the pipe
    always_comb begin
        part_nx = part;
        part_nx[K*CW +: CW] = sum;
    end

    // All stage state advances together and holds during a downstream stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
            a_d     <= '0;
            b_d     <= '0;
            part_d  <= '0;
            carry_d <= 1'b0;
            sub_d   <= 1'b0;
            tag_d   <= '0;
        end else if (en) begin
            valid_d <= valid;
            a_d     <= a;
            b_d     <= b;
            part_d  <= part_nx;
            carry_d <= carry_nx;
            sub_d   <= sub;
            tag_d   <= tag;
        end
    end

endmodule

// File: rtl/restador_segmentado.sv
// restador_segmentado: pipelined add/subtract unit with ALU flags and valid/ready handshake
module restador_segmentado
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             lt_s,
    output logic             lt_u
);

    localparam int CW = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > 4) begin : g_bad_cfg
        $error("restador_segmentado: STAGES must be 1..4 and divide WIDTH");
    end

    logic             v_s [0:STAGES];
    logic [WIDTH-1:0] a_s [0:STAGES];
    logic [WIDTH-1:0] b_s [0:STAGES];
    logic [WIDTH-1:0] r_s [0:STAGES];
    logic             c_s [0:STAGES];
    logic             s_s [0:STAGES];
    logic [TAG_W-1:0] t_s [0:STAGES];

    logic              advance;
    logic              msb_cin;
    logic [NFLAGS-1:0] flags;
    logic              unused_bits;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Subtraction is A + ~B + 1, so the op bit doubles as the chain carry-in
    assign v_s[0] = in_valid;
    assign a_s[0] = A;
    assign b_s[0] = (sub == OP_SUB) ? ~B : B;
    assign r_s[0] = '0;
    assign c_s[0] = sub;
    assign s_s[0] = sub;
    assign t_s[0] = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        restador_etapa #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .K     (k),
            .TAG_W (TAG_W)
        ) u_etapa (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (advance),
            .valid   (v_s[k]),
            .a       (a_s[k]),
            .b       (b_s[k]),
            .part    (r_s[k]),
            .carry   (c_s[k]),
            .sub     (s_s[k]),
            .tag     (t_s[k]),
            .valid_d (v_s[k+1]),
            .a_d     (a_s[k+1]),
            .b_d     (b_s[k+1]),
            .part_d  (r_s[k+1]),
            .carry_d (c_s[k+1]),
            .sub_d   (s_s[k+1]),
            .tag_d   (t_s[k+1])
        );
    end

    assign out_valid = v_s[STAGES];
    assign R         = r_s[STAGES];
    assign out_tag   = t_s[STAGES];

    // The sum bit equals a ^ b ^ carry-in, which recovers the carry into the MSB
    assign msb_cin = a_s[STAGES][WIDTH-1] ^ b_s[STAGES][WIDTH-1] ^ r_s[STAGES][WIDTH-1];

    assign unused_bits = ^{a_s[STAGES][WIDTH-2:0], b_s[STAGES][WIDTH-2:0]};

    // Flags come straight from the final registers, gated so idle and reset read as zero
    always_comb begin
        flags = '0;
        flags[FLAG_Z]   = out_valid & ~|r_s[STAGES];
        flags[FLAG_N]   = out_valid & r_s[STAGES][WIDTH-1];
        flags[FLAG_C]   = out_valid & c_s[STAGES];
        flags[FLAG_V]   = out_valid & (c_s[STAGES] ^ msb_cin);
        flags[FLAG_LTS] = out_valid & s_s[STAGES] & (flags[FLAG_N] ^ flags[FLAG_V]);
        flags[FLAG_LTU] = out_valid & s_s[STAGES] & ~c_s[STAGES];
    end

    assign flag_z = flags[FLAG_Z];
    assign flag_n = flags[FLAG_N];
    assign flag_c = flags[FLAG_C];
    assign flag_v = flags[FLAG_V];
    assign lt_s   = flags[FLAG_LTS];
    assign lt_u   = flags[FLAG_LTU];

endmodule

// File: tb/tb_restador_segmentado.sv
// tb_restador_segmentado: directed self-checking bench for the pipelined add/subtract unit
module tb_restador_segmentado;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        sub;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R;
    logic [4:0]  out_tag;
    logic        flag_z, flag_n, flag_c, flag_v, lt_s, lt_u;
    logic [5:0]  flg;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] op_a  [8];
    logic [31:0] op_b  [8];
    logic        op_s  [8];
    logic [31:0] exp_r [8];

    restador_segmentado #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .out_tag   (out_tag),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .lt_s      (lt_s),
        .lt_u      (lt_u)
    );

    always #5 clk = ~clk;

    assign flg = {flag_z, flag_n, flag_c, flag_v, lt_s, lt_u};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, got, exp);
        end
    endtask

    // Offer one op for one cycle, then wait out the two-stage latency and sample mid-cycle
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [4:0] t);
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; sub = s; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected flag vector order: {Z, N, C, V, lt_s, lt_u}
    task automatic expect_res(input string nm, input logic [31:0] r, input logic [5:0] f, input logic [4:0] t);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_r"}, 64'(R), 64'(r));
        chk({nm, "_flags"}, 64'(flg), 64'(f));
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    endtask

    initial begin
        int idx, oidx, cyc;
        logic acc, stall;
        logic [31:0] hr;
        logic [4:0] ht;

        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_r", 64'(R), 64'd0);
        chk("rst_flags", 64'(flg), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        do_op(32'd40, 32'd21, 1'b1, 5'd3);
        expect_res("sub_basic", 32'd19, 6'b001000, 5'd3);
        do_op(32'd20, 32'd40, 1'b1, 5'd4);
        expect_res("sub_neg", 32'hFFFF_FFEC, 6'b010011, 5'd4);
        do_op(32'd20, 32'd20, 1'b1, 5'd5);
        expect_res("sub_zero", 32'd0, 6'b101000, 5'd5);
        do_op(32'hFFFF_FFE7, 32'd20, 1'b1, 5'd6);
        expect_res("sub_signed", 32'hFFFF_FFD3, 6'b011010, 5'd6);
        do_op(32'h8000_0000, 32'd1, 1'b1, 5'd7);
        expect_res("sub_ovf", 32'h7FFF_FFFF, 6'b001110, 5'd7);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 5'd8);
        expect_res("add_wrap", 32'd0, 6'b101000, 5'd8);
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 5'd9);
        expect_res("add_ovf", 32'h8000_0000, 6'b010100, 5'd9);
        do_op(32'h0000_FFFF, 32'd1, 1'b0, 5'd10);
        expect_res("add_chunk_carry", 32'h0001_0000, 6'b000000, 5'd10);
        do_op(32'h0001_0000, 32'd1, 1'b1, 5'd11);
        expect_res("sub_chunk_borrow", 32'h0000_FFFF, 6'b001000, 5'd11);

        // Back-to-back stream with the consumer stalling in cycles 3..5
        for (int i = 0; i < 8; i++) begin
            op_a[i]  = 32'h0000_FFF0 + 32'h0001_0000 * i + i;
            op_b[i]  = 32'h20 + i;
            op_s[i]  = i[0];
            exp_r[i] = op_s[i] ? op_a[i] - op_b[i] : op_a[i] + op_b[i];
        end
        idx = 0; oidx = 0; cyc = 0; acc = 1'b0; stall = 1'b0; hr = '0; ht = '0;
        while (oidx < 8 && cyc < 40) begin
            @(posedge clk); #1;
            if (acc) idx++;
            in_valid = (idx < 8);
            if (idx < 8) begin
                A = op_a[idx]; B = op_b[idx]; sub = op_s[idx]; in_tag = 5'(idx + 16);
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (stall) begin
                chk("bp_hold_r", 64'(R), 64'(hr));
                chk("bp_hold_tag", 64'(out_tag), 64'(ht));
            end
            chk("bp_in_ready", 64'(in_ready), 64'(out_ready));
            acc = in_valid & in_ready;
            stall = out_valid & ~out_ready;
            hr = R;
            ht = out_tag;
            if (out_valid && out_ready) begin
                chk("bp_r", 64'(R), 64'(exp_r[oidx]));
                chk("bp_tag", 64'(out_tag), 64'(oidx + 16));
                oidx++;
            end
            cyc++;
        end
        chk("bp_count", 64'(oidx), 64'd8);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_dup", 64'(out_valid), 64'd0);
        end

        // Reset with two ops in flight
        @(posedge clk); #1;
        in_valid = 1'b1; A = 32'd5; B = 32'd6; sub = 1'b0; in_tag = 5'd12;
        @(posedge clk); #1;
        A = 32'd9; B = 32'd1; sub = 1'b1; in_tag = 5'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_r", 64'(R), 64'd0);
        chk("async_rst_flags", 64'(flg), 64'd0);
        chk("async_rst_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_out", 64'(out_valid), 64'd0);
        end
        do_op(32'd100, 32'd1, 1'b1, 5'd14);
        expect_res("post_rst_op", 32'd99, 6'b001000, 5'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
